adam_axil_to_mem: RTL and testbench

AXI-Lite slave that terminates one core-side AXI-Lite port (instruction or data) onto a single-port, 1-cycle-latency SRAM macro. Sits directly downstream of the core's OBI-to-AXI-Lite bridges. Serializes reads and writes with round-robin arbitration and honours the ADAM pause handshake so the memory can be quiesced for reconfiguration or debug.

---
 rtl/adam_axil_to_mem.sv | 222 ++++++++++++++++++++++
 tb/tb_adam_axil_to_mem.sv | 493 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adam_axil_to_mem.sv
// ---------------------------------------------------------------------------
// adam_axil_to_mem
//
// AXI-Lite slave that terminates one core-side AXI-Lite port onto a
// single-port SRAM macro with one cycle of read latency. Reads and writes are
// serialized through a small FSM. When a complete write and a read arrive in
// the same cycle, a round-robin pointer decides which one goes first. The
// pause handshake lets the memory be quiesced: new transactions are refused
// and ack is raised once the block is idle with nothing buffered.
//
// Ports
//   i_clk, i_rst         clock (rising edge), asynchronous active-high reset
//   i_pause_req          request to quiesce
//   o_pause_ack          idle, nothing buffered, new transactions refused
//   i_axil_aw*/o_axil_awready   write address channel
//   i_axil_w*/o_axil_wready     write data channel (data + byte strobes)
//   o_axil_b*/i_axil_bready     write response channel (always OKAY)
//   i_axil_ar*/o_axil_arready   read address channel
//   o_axil_r*/i_axil_rready     read data channel (always OKAY)
//   o_mem_req            SRAM access strobe, one cycle per access
//   o_mem_we             1 = write, 0 = read
//   o_mem_addr           word address (byte offset dropped, upper bits alias)
//   o_mem_be             byte enables (write strobe, all-ones on read)
//   o_mem_wdata          write data
//   i_mem_rdata          read data, valid the cycle after a read strobe
// ---------------------------------------------------------------------------
module adam_axil_to_mem #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int MEM_WORDS  = 1024,
   localparam int STRB_WIDTH = DATA_WIDTH / 8,
   localparam int MEM_AW     = $clog2(MEM_WORDS),
   localparam int BYTE_OFS   = $clog2(STRB_WIDTH)
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_pause_req,
   output logic                  o_pause_ack,
   input  logic [ADDR_WIDTH-1:0] i_axil_awaddr,
   input  logic                  i_axil_awvalid,
   output logic                  o_axil_awready,
   input  logic [DATA_WIDTH-1:0] i_axil_wdata,
   input  logic [STRB_WIDTH-1:0] i_axil_wstrb,
   input  logic                  i_axil_wvalid,
   output logic                  o_axil_wready,
   output logic [1:0]            o_axil_bresp,
   output logic                  o_axil_bvalid,
   input  logic                  i_axil_bready,
   input  logic [ADDR_WIDTH-1:0] i_axil_araddr,
   input  logic                  i_axil_arvalid,
   output logic                  o_axil_arready,
   output logic [DATA_WIDTH-1:0] o_axil_rdata,
   output logic [1:0]            o_axil_rresp,
   output logic                  o_axil_rvalid,
   input  logic                  i_axil_rready,
   output logic                  o_mem_req,
   output logic                  o_mem_we,
   output logic [MEM_AW-1:0]     o_mem_addr,
   output logic [STRB_WIDTH-1:0] o_mem_be,
   output logic [DATA_WIDTH-1:0] o_mem_wdata,
   input  logic [DATA_WIDTH-1:0] i_mem_rdata
);

   typedef enum logic [2:0] {
      IDLE,
      RD_ACC,
      RD_CAP,
      RD_RESP,
      WR_ACC,
      WR_RESP
   } StateType;

   StateType                r_state;
   StateType                w_stateNext;
   logic                    r_active;
   logic                    r_awFull;
   logic                    r_wFull;
   logic                    r_arFull;
   logic                    r_rrReadFirst;
   logic [MEM_AW-1:0]       r_awAddr;
   logic [MEM_AW-1:0]       r_arAddr;
   logic [DATA_WIDTH-1:0]   r_wData;
   logic [STRB_WIDTH-1:0]   r_wStrb;
   logic [DATA_WIDTH-1:0]   r_rdata;
   logic                    r_pauseAck;
   logic                    w_awFullNext;
   logic                    w_wFullNext;
   logic                    w_arFullNext;
   logic                    w_rrReadFirstNext;
   logic                    w_awHs;
   logic                    w_wHs;
   logic                    w_arHs;
   logic                    w_wrGo;
   logic                    w_rdGo;
   logic                    w_unusedAddr;

   // Only the word-address slice of the AXI addresses reaches the SRAM; the
   // byte offset and anything above the array size are deliberately dropped.
   assign w_unusedAddr = ^{i_axil_awaddr, i_axil_araddr};

   // Ready generation. r_active keeps every ready low until the first edge
   // after reset release. While paused, AW and AR are refused, but a write
   // whose address is already held may still take its data beat so it can
   // drain. AR is only taken from IDLE with no complete write or read queued.
   assign o_axil_awready = r_active && !r_awFull && !i_pause_req;
   assign o_axil_wready  = r_active && !r_wFull && (!i_pause_req || r_awFull);
   assign o_axil_arready = r_active && (r_state == IDLE) && !r_arFull &&
                           !(r_awFull && r_wFull) && !i_pause_req;

   assign w_awHs = i_axil_awvalid && o_axil_awready;
   assign w_wHs  = i_axil_wvalid && o_axil_wready;
   assign w_arHs = i_axil_arvalid && o_axil_arready;

   // A write may launch in the same cycle its last beat arrives, which is
   // what gives the one-cycle handshake-to-strobe latency.
   assign w_wrGo = (r_awFull || w_awHs) && (r_wFull || w_wHs);
   assign w_rdGo = r_arFull || w_arHs;

   // Memory-side and response outputs decode straight from the state
   // register, so they are glitch-free and all zero in IDLE and in reset.
   assign o_mem_req     = (r_state == RD_ACC) || (r_state == WR_ACC);
   assign o_mem_we      = (r_state == WR_ACC);
   assign o_mem_addr    = (r_state == WR_ACC) ? r_awAddr :
                          (r_state == RD_ACC) ? r_arAddr : '0;
   assign o_mem_be      = (r_state == WR_ACC) ? r_wStrb :
                          (r_state == RD_ACC) ? {STRB_WIDTH{1'b1}} : '0;
   assign o_mem_wdata   = (r_state == WR_ACC) ? r_wData : '0;
   assign o_axil_rvalid = (r_state == RD_RESP);
   assign o_axil_bvalid = (r_state == WR_RESP);
   assign o_axil_rdata  = r_rdata;
   assign o_axil_rresp  = 2'b00;
   assign o_axil_bresp  = 2'b00;
   assign o_pause_ack   = r_pauseAck;

   // Next-state logic. In IDLE a contested cycle (complete write and a read
   // at once) is resolved by the round-robin pointer. The pointer only moves
   // on contested grants, so uncontested traffic never skews the fairness
   // between the two. A read that loses is parked in the AR holder and
   // served as soon as the FSM returns to IDLE.
   always_comb begin
      w_stateNext       = r_state;
      w_awFullNext      = r_awFull || w_awHs;
      w_wFullNext       = r_wFull || w_wHs;
      w_arFullNext      = r_arFull;
      w_rrReadFirstNext = r_rrReadFirst;
      case (r_state)
         IDLE: begin
            if (w_wrGo && w_rdGo) begin
               if (r_rrReadFirst) begin
                  w_stateNext  = RD_ACC;
                  w_arFullNext = 1'b0;
               end else begin
                  w_stateNext  = WR_ACC;
                  w_arFullNext = 1'b1;
               end
               w_rrReadFirstNext = !r_rrReadFirst;
            end else if (w_wrGo) begin
               w_stateNext = WR_ACC;
            end else if (w_rdGo) begin
               w_stateNext  = RD_ACC;
               w_arFullNext = 1'b0;
            end
         end
         RD_ACC:  w_stateNext = RD_CAP;
         RD_CAP:  w_stateNext = RD_RESP;
         RD_RESP: if (i_axil_rready) w_stateNext = IDLE;
         WR_ACC: begin
            w_stateNext  = WR_RESP;
            w_awFullNext = 1'b0;
            w_wFullNext  = 1'b0;
         end
         WR_RESP: if (i_axil_bready) w_stateNext = IDLE;
         default: w_stateNext = IDLE;
      endcase
   end

   // State register. Reset drops straight back to IDLE, which kills any
   // valid or memory strobe in the same instant.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_stateNext;
      end
   end

   // Holders, arbitration pointer, captured read data and pause ack. The ack
   // looks at where the FSM and holders will be next cycle, so it rises the
   // cycle right after the final response handshake and falls the cycle
   // after the request is withdrawn.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_active      <= 1'b0;
         r_awFull      <= 1'b0;
         r_wFull       <= 1'b0;
         r_arFull      <= 1'b0;
         r_rrReadFirst <= 1'b0;
         r_awAddr      <= '0;
         r_arAddr      <= '0;
         r_wData       <= '0;
         r_wStrb       <= '0;
         r_rdata       <= '0;
         r_pauseAck    <= 1'b0;
      end else begin
         r_active      <= 1'b1;
         r_awFull      <= w_awFullNext;
         r_wFull       <= w_wFullNext;
         r_arFull      <= w_arFullNext;
         r_rrReadFirst <= w_rrReadFirstNext;
         if (w_awHs) r_awAddr <= i_axil_awaddr[MEM_AW+BYTE_OFS-1:BYTE_OFS];
         if (w_arHs) r_arAddr <= i_axil_araddr[MEM_AW+BYTE_OFS-1:BYTE_OFS];
         if (w_wHs) begin
            r_wData <= i_axil_wdata;
            r_wStrb <= i_axil_wstrb;
         end
         if (r_state == RD_CAP) r_rdata <= i_mem_rdata;
         r_pauseAck <= i_pause_req && (w_stateNext == IDLE) &&
                       !w_awFullNext && !w_wFullNext && !w_arFullNext;
      end
   end

endmodule

// File: tb/tb_adam_axil_to_mem.sv
// ---------------------------------------------------------------------------
// tb_adam_axil_to_mem
//
// Bench for adam_axil_to_mem. A behavioural SRAM answers the memory port.
// A reference model keeps a word array plus the ordered lists of SRAM
// accesses and read responses the design must produce. A compare process
// checks every memory strobe and every response against that model, while
// the directed sequences pin latencies and a few literal values by hand.
// ---------------------------------------------------------------------------
module tb_adam_axil_to_mem;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        pauseReq = 1'b0;
   logic        pauseAck;
   logic [31:0] awAddr = '0;
   logic        awValid = 1'b0;
   logic        awReady;
   logic [31:0] wData = '0;
   logic [3:0]  wStrb = '0;
   logic        wValid = 1'b0;
   logic        wReady;
   logic [1:0]  bResp;
   logic        bValid;
   logic        bReady = 1'b1;
   logic [31:0] arAddr = '0;
   logic        arValid = 1'b0;
   logic        arReady;
   logic [31:0] rData;
   logic [1:0]  rResp;
   logic        rValid;
   logic        rReady = 1'b1;
   logic        memReq;
   logic        memWe;
   logic [9:0]  memAddr;
   logic [3:0]  memBe;
   logic [31:0] memWdata;
   logic [31:0] memRdata = '0;

   always #5 clk = ~clk;

   adam_axil_to_mem #(
      .ADDR_WIDTH(32),
      .DATA_WIDTH(32),
      .MEM_WORDS (1024)
   ) dut (
      .i_clk         (clk),
      .i_rst         (rst),
      .i_pause_req   (pauseReq),
      .o_pause_ack   (pauseAck),
      .i_axil_awaddr (awAddr),
      .i_axil_awvalid(awValid),
      .o_axil_awready(awReady),
      .i_axil_wdata  (wData),
      .i_axil_wstrb  (wStrb),
      .i_axil_wvalid (wValid),
      .o_axil_wready (wReady),
      .o_axil_bresp  (bResp),
      .o_axil_bvalid (bValid),
      .i_axil_bready (bReady),
      .i_axil_araddr (arAddr),
      .i_axil_arvalid(arValid),
      .o_axil_arready(arReady),
      .o_axil_rdata  (rData),
      .o_axil_rresp  (rResp),
      .o_axil_rvalid (rValid),
      .i_axil_rready (rReady),
      .o_mem_req     (memReq),
      .o_mem_we      (memWe),
      .o_mem_addr    (memAddr),
      .o_mem_be      (memBe),
      .o_mem_wdata   (memWdata),
      .i_mem_rdata   (memRdata)
   );

   typedef struct {
      logic        we;
      logic [9:0]  addr;
      logic [3:0]  be;
      logic [31:0] wdata;
   } AccessType;

   int          testsRun = 0;
   int          testsFailed = 0;
   AccessType   expAcc[$];
   logic [31:0] expRd[$];
   logic [31:0] modelMem [1024];
   logic [31:0] sram [1024];
   AccessType   curAcc;
   logic [31:0] rdVal;

   task automatic checkOutput(input string name, input logic [63:0] actual,
                              input logic [63:0] expected);
      testsRun++;
      if (actual !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: actual 0x%0h required 0x%0h", name, actual, expected);
      end
   endtask

   function automatic logic [31:0] mergeBytes(input logic [31:0] oldWord,
                                              input logic [31:0] newWord,
                                              input logic [3:0] be);
      logic [31:0] res;
      res = oldWord;
      for (int b = 0; b < 4; b++) begin
         if (be[b]) res[8*b +: 8] = newWord[8*b +: 8];
      end
      return res;
   endfunction

   // Reference model: record the SRAM write the design must issue and apply
   // it to the model array.
   task automatic expectWrite(input logic [31:0] addr, input logic [31:0] data,
                              input logic [3:0] strb);
      AccessType a;
      a.we    = 1'b1;
      a.addr  = addr[11:2];
      a.be    = strb;
      a.wdata = data;
      expAcc.push_back(a);
      modelMem[addr[11:2]] = mergeBytes(modelMem[addr[11:2]], data, strb);
   endtask

   // Reference model: record the SRAM read and the response data it yields.
   task automatic expectRead(input logic [31:0] addr);
      AccessType a;
      a.we    = 1'b0;
      a.addr  = addr[11:2];
      a.be    = 4'hF;
      a.wdata = '0;
      expAcc.push_back(a);
      expRd.push_back(modelMem[addr[11:2]]);
   endtask

   // Behavioural single-port SRAM with one cycle of read latency.
   always @(posedge clk) begin
      if (memReq) begin
         if (memWe) begin
            sram[memAddr] <= mergeBytes(sram[memAddr], memWdata, memBe);
         end else begin
            memRdata <= sram[memAddr];
         end
      end
   end

   // Compare process: every strobe and every response against the model.
   always @(negedge clk) begin
      if (!rst) begin
         if (memReq) begin
            if (expAcc.size() == 0) begin
               checkOutput("unexpected_mem_req", {63'd0, memReq}, 64'd0);
            end else begin
               curAcc = expAcc.pop_front();
               checkOutput("model_mem_we", memWe, curAcc.we);
               checkOutput("model_mem_addr", memAddr, curAcc.addr);
               checkOutput("model_mem_be", memBe, curAcc.be);
               if (curAcc.we) checkOutput("model_mem_wdata", memWdata, curAcc.wdata);
            end
         end
         if (rValid && rReady) begin
            if (expRd.size() == 0) begin
               checkOutput("unexpected_rvalid", {63'd0, rValid}, 64'd0);
            end else begin
               checkOutput("model_rdata", rData, expRd.pop_front());
            end
            checkOutput("model_rresp", rResp, 2'b00);
         end
         if (bValid && bReady) checkOutput("model_bresp", bResp, 2'b00);
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic awv, input logic [31:0] awa,
                                input logic wv, input logic [31:0] wd,
                                input logic [3:0] ws, input logic arv,
                                input logic [31:0] ara);
      awValid = awv;
      awAddr  = awa;
      wValid  = wv;
      wData   = wd;
      wStrb   = ws;
      arValid = arv;
      arAddr  = ara;
   endtask

   task automatic waitB();
      logic seen;
      seen = 1'b0;
      bReady = 1'b1;
      for (int n = 0; n < 20 && !seen; n++) begin
         @(negedge clk);
         if (bValid) seen = 1'b1;
         step();
      end
      checkOutput("bvalid_timeout", seen, 1'b1);
   endtask

   task automatic waitR(output logic [31:0] d);
      logic seen;
      seen = 1'b0;
      d = '0;
      rReady = 1'b1;
      for (int n = 0; n < 20 && !seen; n++) begin
         @(negedge clk);
         if (rValid) begin
            seen = 1'b1;
            d = rData;
         end
         step();
      end
      checkOutput("rvalid_timeout", seen, 1'b1);
   endtask

   task automatic doWrite(input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] strb);
      logic awDone;
      logic wDone;
      awDone = 1'b0;
      wDone  = 1'b0;
      expectWrite(addr, data, strb);
      applyStimulus(1'b1, addr, 1'b1, data, strb, 1'b0, '0);
      for (int n = 0; n < 20 && !(awDone && wDone); n++) begin
         @(negedge clk);
         if (awValid && awReady) awDone = 1'b1;
         if (wValid && wReady) wDone = 1'b1;
         step();
         if (awDone) awValid = 1'b0;
         if (wDone) wValid = 1'b0;
      end
      checkOutput("write_accept", {awDone, wDone}, 2'b11);
      waitB();
   endtask

   task automatic doRead(input logic [31:0] addr, output logic [31:0] d);
      logic arDone;
      arDone = 1'b0;
      expectRead(addr);
      applyStimulus(1'b0, '0, 1'b0, '0, '0, 1'b1, addr);
      for (int n = 0; n < 20 && !arDone; n++) begin
         @(negedge clk);
         if (arReady) arDone = 1'b1;
         step();
         if (arDone) arValid = 1'b0;
      end
      checkOutput("read_accept", arDone, 1'b1);
      waitR(d);
   endtask

   task automatic applyReset();
      applyStimulus(1'b0, '0, 1'b0, '0, '0, 1'b0, '0);
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
      step();
      step();
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: time limit reached, testsRun=%0d", testsRun);
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      for (int i = 0; i < 1024; i++) modelMem[i] = '0;

      // Reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      checkOutput("reset_readys", {awReady, wReady, arReady}, 3'b000);
      checkOutput("reset_valids", {rValid, bValid}, 2'b00);
      checkOutput("reset_mem_ctl", {memReq, memWe, memBe}, 6'd0);
      checkOutput("reset_mem_addr", memAddr, 10'd0);
      checkOutput("reset_mem_wdata", memWdata, 32'd0);
      checkOutput("reset_pause_ack", pauseAck, 1'b0);
      step();
      rst = 1'b0;
      @(negedge clk);
      checkOutput("release_readys_low", {awReady, wReady, arReady}, 3'b000);
      step();
      @(negedge clk);
      checkOutput("readys_after_release", {awReady, wReady, arReady}, 3'b111);

      // Test 1: AW and W together, then readback with exact latencies
      step();
      expectWrite(32'h10, 32'hDEADBEEF, 4'hF);
      applyStimulus(1'b1, 32'h10, 1'b1, 32'hDEADBEEF, 4'hF, 1'b0, '0);
      @(negedge clk);
      checkOutput("t1_aw_w_ready", {awReady, wReady}, 2'b11);
      step();
      applyStimulus(1'b0, '0, 1'b0, '0, '0, 1'b0, '0);
      @(negedge clk);
      checkOutput("t1_mem_req_we_n1", {memReq, memWe}, 2'b11);
      checkOutput("t1_mem_addr", memAddr, 10'd4);
      step();
      @(negedge clk);
      checkOutput("t1_bvalid_n2", bValid, 1'b1);
      step();
      @(negedge clk);
      checkOutput("t1_bvalid_drop", bValid, 1'b0);
      step();
      expectRead(32'h10);
      applyStimulus(1'b0, '0, 1'b0, '0, '0, 1'b1, 32'h10);
      @(negedge clk);
      checkOutput("t1_arready", arReady, 1'b1);
      step();
      arValid = 1'b0;
      @(negedge clk);
      checkOutput("t1_rd_mem_req", {memReq, memWe, memBe}, 6'b10_1111);
      checkOutput("t1_rd_mem_addr", memAddr, 10'd4);
      step();
      @(negedge clk);
      checkOutput("t1_rvalid_not_n2", rValid, 1'b0);
      step();
      @(negedge clk);
      checkOutput("t1_rvalid_n3", rValid, 1'b1);
      checkOutput("t1_rdata", rData, 32'hDEADBEEF);
      step();

      // Test 2: W three cycles ahead of AW, partial strobe over all-ones
      doWrite(32'h20, 32'hFFFFFFFF, 4'hF);
      expectWrite(32'h20, 32'h0000CAFE, 4'h3);
      applyStimulus(1'b0, '0, 1'b1, 32'h0000CAFE, 4'h3, 1'b0, '0);
      @(negedge clk);
      checkOutput("t2_wready", wReady, 1'b1);
      step();
      wValid = 1'b0;
      @(negedge clk);
      checkOutput("t2_w_held", wReady, 1'b0);
      checkOutput("t2_no_early_req", memReq, 1'b0);
      step();
      step();
      applyStimulus(1'b1, 32'h20, 1'b0, '0, '0, 1'b0, '0);
      @(negedge clk);
      checkOutput("t2_awready", awReady, 1'b1);
      step();
      awValid = 1'b0;
      @(negedge clk);
      checkOutput("t2_mem_req", memReq, 1'b1);
      checkOutput("t2_mem_be", memBe, 4'h3);
      waitB();
      doRead(32'h20, rdVal);
      checkOutput("t2_readback", rdVal, 32'hFFFFCAFE);

      // Test 3: contested cycles alternate between write and read
      applyReset();
      expectWrite(32'h30, 32'h11112222, 4'hF);
      expectRead(32'h30);
      applyStimulus(1'b1, 32'h30, 1'b1, 32'h11112222, 4'hF, 1'b1, 32'h30);
      @(negedge clk);
      checkOutput("t3a_all_ready", {awReady, wReady, arReady}, 3'b111);
      step();
      applyStimulus(1'b0, '0, 1'b0, '0, '0, 1'b0, '0);
      @(negedge clk);
      checkOutput("t3a_write_first", {memReq, memWe}, 2'b11);
      waitB();
      waitR(rdVal);
      checkOutput("t3a_read_sees_write", rdVal, 32'h11112222);
      doWrite(32'h34, 32'h55556666, 4'hF);
      expectRead(32'h34);
      expectWrite(32'h34, 32'h33334444, 4'hF);
      applyStimulus(1'b1, 32'h34, 1'b1, 32'h33334444, 4'hF, 1'b1, 32'h34);
      @(negedge clk);
      checkOutput("t3b_all_ready", {awReady, wReady, arReady}, 3'b111);
      step();
      applyStimulus(1'b0, '0, 1'b0, '0, '0, 1'b0, '0);
      @(negedge clk);
      checkOutput("t3b_read_first", {memReq, memWe}, 2'b10);
      waitR(rdVal);
      checkOutput("t3b_read_old_data", rdVal, 32'h55556666);
      waitB();
      doRead(32'h34, rdVal);
      checkOutput("t3b_final_data", rdVal, 32'h33334444);

      // Test 4: rready held low, response must hold and nothing new enters
      expectRead(32'h10);
      rReady = 1'b0;
      applyStimulus(1'b0, '0, 1'b0, '0, '0, 1'b1, 32'h10);
      @(negedge clk);
      checkOutput("t4_arready", arReady, 1'b1);
      step();
      arValid = 1'b0;
      step();
      step();
      applyStimulus(1'b0, '0, 1'b0, '0, '0, 1'b1, 32'h20);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         checkOutput("t4_rvalid_hold", rValid, 1'b1);
         checkOutput("t4_rdata_hold", rData, 32'hDEADBEEF);
         checkOutput("t4_no_new_ar", arReady, 1'b0);
         step();
      end
      rReady = 1'b1;
      arValid = 1'b0;
      @(negedge clk);
      checkOutput("t4_rvalid_at_hs", rValid, 1'b1);
      step();
      @(negedge clk);
      checkOutput("t4_rvalid_drop", {rValid, memReq}, 2'b00);
      step();

      // Test 5: pause with a half-collected write
      expectWrite(32'h40, 32'h0BADF00D, 4'hF);
      expectRead(32'h40);
      applyStimulus(1'b1, 32'h40, 1'b0, '0, '0, 1'b0, '0);
      @(negedge clk);
      checkOutput("t5_awready", awReady, 1'b1);
      step();
      awValid = 1'b0;
      pauseReq = 1'b1;
      @(negedge clk);
      checkOutput("t5_aw_blocked", awReady, 1'b0);
      checkOutput("t5_w_open", wReady, 1'b1);
      checkOutput("t5_ar_blocked", arReady, 1'b0);
      checkOutput("t5_no_ack_busy", pauseAck, 1'b0);
      step();
      step();
      applyStimulus(1'b0, '0, 1'b1, 32'h0BADF00D, 4'hF, 1'b0, '0);
      @(negedge clk);
      checkOutput("t5_w_accepted", wReady, 1'b1);
      step();
      wValid = 1'b0;
      @(negedge clk);
      checkOutput("t5_mem_write", {memReq, memWe}, 2'b11);
      step();
      @(negedge clk);
      checkOutput("t5_bvalid", bValid, 1'b1);
      checkOutput("t5_no_ack_at_hs", pauseAck, 1'b0);
      step();
      applyStimulus(1'b0, '0, 1'b0, '0, '0, 1'b1, 32'h40);
      @(negedge clk);
      checkOutput("t5_ack", pauseAck, 1'b1);
      checkOutput("t5_ar_refused", arReady, 1'b0);
      for (int i = 0; i < 3; i++) begin
         step();
         @(negedge clk);
         checkOutput("t5_ar_refused_hold", arReady, 1'b0);
         checkOutput("t5_ack_hold", pauseAck, 1'b1);
      end
      step();
      pauseReq = 1'b0;
      @(negedge clk);
      checkOutput("t5_ar_after_release", arReady, 1'b1);
      checkOutput("t5_ack_one_more", pauseAck, 1'b1);
      step();
      arValid = 1'b0;
      @(negedge clk);
      checkOutput("t5_ack_drop", pauseAck, 1'b0);
      waitR(rdVal);
      checkOutput("t5_readback", rdVal, 32'h0BADF00D);

      // Test 6: reset pulsed while a read is capturing
      expectRead(32'h10);
      applyStimulus(1'b0, '0, 1'b0, '0, '0, 1'b1, 32'h10);
      @(negedge clk);
      checkOutput("t6_arready", arReady, 1'b1);
      step();
      arValid = 1'b0;
      @(negedge clk);
      checkOutput("t6_mem_req", memReq, 1'b1);
      step();
      rst = 1'b1;
      @(negedge clk);
      checkOutput("t6_rst_valids", {rValid, bValid, memReq, memWe}, 4'd0);
      checkOutput("t6_rst_readys", {awReady, wReady, arReady, pauseAck}, 4'd0);
      checkOutput("t6_rst_mem_bus", {memAddr, memBe}, 14'd0);
      for (int i = 0; i < 2; i++) begin
         step();
         @(negedge clk);
         checkOutput("t6_rvalid_never", {rValid, memReq}, 2'b00);
      end
      expRd.delete();
      checkOutput("t6_acc_drained", expAcc.size(), 0);
      step();
      rst = 1'b0;
      step();
      doRead(32'h10, rdVal);
      checkOutput("t6_read_after_reset", rdVal, 32'hDEADBEEF);

      step();
      checkOutput("final_acc_queue", expAcc.size(), 0);
      checkOutput("final_rd_queue", expRd.size(), 0);
      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
